// File: rtl/proc_reset_sequencer.sv
// proc_reset_sequencer
// Staged reset release for the processor subsystem. Waits until PLL lock,
// device initialisation and the external reset request are all good and
// stable, then releases the fabric, peripheral and CPU resets in that order.
// Any loss of a good input drops all three resets together and restarts the
// sequence from the stability wait.
//
// state        | meaning
// -------------+------------------------------------------------------------
// RESET_HOLD   | entered only by RESETN; leaves on the first clock edge
// WAIT_INPUTS  | all resets asserted, waiting for good=1
// STABILIZE    | good=1, counting LOCK_CYCLES of uninterrupted good
// REL_FABRIC   | fabric released, counting STAGE_DELAY before peripheral
// REL_PERIPH   | fabric+peripheral released, counting STAGE_DELAY before CPU
// RUN          | everything released, SEQ_DONE high, watching for input loss
//
// RESETN acts asynchronously on both edges inside this block; release timing
// relative to CLK is the responsibility of the reset bridge feeding RESETN.

module proc_reset_sequencer #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       PLL_LOCK,
    input  logic       INIT_DONE,
    input  logic       EXT_RST_N,
    output logic       FABRIC_RESET_N,
    output logic       PERIPH_RESET_N,
    output logic       CPU_RESET_N,
    output logic       SEQ_DONE,
    output logic [7:0] LOCK_LOSS_CNT
);

    localparam logic [2:0] S_RESET_HOLD  = 3'd0;
    localparam logic [2:0] S_WAIT_INPUTS = 3'd1;
    localparam logic [2:0] S_STABILIZE   = 3'd2;
    localparam logic [2:0] S_REL_FABRIC  = 3'd3;
    localparam logic [2:0] S_REL_PERIPH  = 3'd4;
    localparam logic [2:0] S_RUN         = 3'd5;

    // Terminal-count values for the shared 16-bit counter.
    localparam logic [15:0] LOCK_TC  = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] STAGE_TC = 16'(STAGE_DELAY - 1);

    localparam logic [7:0] LOSS_MAX = 8'hFF;

    // Synchroniser bit order: {PLL_LOCK, INIT_DONE, EXT_RST_N}.
    logic [2:0]  meta_d, meta_q;
    logic [2:0]  sync_d, sync_q;

    logic [2:0]  state_d, state_q;
    logic [15:0] cnt_d, cnt_q;
    logic        fabric_rst_n_d, fabric_rst_n_q;
    logic        periph_rst_n_d, periph_rst_n_q;
    logic        cpu_rst_n_d, cpu_rst_n_q;
    logic        seq_done_d, seq_done_q;
    logic [7:0]  loss_cnt_d, loss_cnt_q;

    logic        good;
    logic        pll_ok;

    assign good   = &sync_q;
    assign pll_ok = sync_q[2];

    // Two-flop synchroniser input and second stage.
    always_comb begin
        meta_d = {PLL_LOCK, INIT_DONE, EXT_RST_N};
        sync_d = meta_q;
    end

    // Synchroniser flops; reset to "not good" so nothing releases early.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    // Sequencer next-state, counter and output decisions.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fabric_rst_n_d = fabric_rst_n_q;
        periph_rst_n_d = periph_rst_n_q;
        cpu_rst_n_d    = cpu_rst_n_q;
        seq_done_d     = seq_done_q;
        loss_cnt_d     = loss_cnt_q;

        case (state_q)
            S_RESET_HOLD: begin
                state_d        = S_WAIT_INPUTS;
                cnt_d          = 16'd0;
                fabric_rst_n_d = 1'b0;
                periph_rst_n_d = 1'b0;
                cpu_rst_n_d    = 1'b0;
                seq_done_d     = 1'b0;
            end

            S_WAIT_INPUTS: begin
                if (good) begin
                    state_d = S_STABILIZE;
                    cnt_d   = 16'd0;
                end
            end

            S_STABILIZE: begin
                if (!good) begin
                    state_d = S_WAIT_INPUTS;
                    cnt_d   = 16'd0;
                end else if (cnt_q == LOCK_TC) begin
                    state_d        = S_REL_FABRIC;
                    cnt_d          = 16'd0;
                    fabric_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_REL_FABRIC: begin
                if (!good) begin
                    state_d        = S_WAIT_INPUTS;
                    cnt_d          = 16'd0;
                    fabric_rst_n_d = 1'b0;
                    periph_rst_n_d = 1'b0;
                    cpu_rst_n_d    = 1'b0;
                    seq_done_d     = 1'b0;
                end else if (cnt_q == STAGE_TC) begin
                    state_d        = S_REL_PERIPH;
                    cnt_d          = 16'd0;
                    periph_rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_REL_PERIPH: begin
                if (!good) begin
                    state_d        = S_WAIT_INPUTS;
                    cnt_d          = 16'd0;
                    fabric_rst_n_d = 1'b0;
                    periph_rst_n_d = 1'b0;
                    cpu_rst_n_d    = 1'b0;
                    seq_done_d     = 1'b0;
                end else if (cnt_q == STAGE_TC) begin
                    state_d     = S_RUN;
                    cnt_d       = 16'd0;
                    cpu_rst_n_d = 1'b1;
                    seq_done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_RUN: begin
                if (!good) begin
                    state_d        = S_WAIT_INPUTS;
                    cnt_d          = 16'd0;
                    fabric_rst_n_d = 1'b0;
                    periph_rst_n_d = 1'b0;
                    cpu_rst_n_d    = 1'b0;
                    seq_done_d     = 1'b0;
                    // Only a PLL lock loss is logged; INIT_DONE/EXT_RST_N drops are not.
                    if (!pll_ok && (loss_cnt_q != LOSS_MAX)) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d        = S_WAIT_INPUTS;
                cnt_d          = 16'd0;
                fabric_rst_n_d = 1'b0;
                periph_rst_n_d = 1'b0;
                cpu_rst_n_d    = 1'b0;
                seq_done_d     = 1'b0;
            end
        endcase
    end

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q        <= S_RESET_HOLD;
            cnt_q          <= 16'd0;
            fabric_rst_n_q <= 1'b0;
            periph_rst_n_q <= 1'b0;
            cpu_rst_n_q    <= 1'b0;
            seq_done_q     <= 1'b0;
            loss_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fabric_rst_n_q <= fabric_rst_n_d;
            periph_rst_n_q <= periph_rst_n_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            seq_done_q     <= seq_done_d;
            loss_cnt_q     <= loss_cnt_d;
        end
    end

    assign FABRIC_RESET_N = fabric_rst_n_q;
    assign PERIPH_RESET_N = periph_rst_n_q;
    assign CPU_RESET_N    = cpu_rst_n_q;
    assign SEQ_DONE       = seq_done_q;
    assign LOCK_LOSS_CNT  = loss_cnt_q;

endmodule

// File: tb/tb_proc_reset_sequencer.sv
// Directed bench for proc_reset_sequencer (LOCK_CYCLES=8, STAGE_DELAY=4)
// plus a default-parameter instance for the long-count timing.
module tb_proc_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       PLL_LOCK = 1'b0;
    logic       INIT_DONE = 1'b0;
    logic       EXT_RST_N = 1'b0;
    logic       FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE;
    logic [7:0] LOCK_LOSS_CNT;
    logic       def_fabric, def_periph, def_cpu, def_done;
    logic [7:0] def_loss;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;

    always #5 CLK = ~CLK;

    proc_reset_sequencer #(.LOCK_CYCLES(8), .STAGE_DELAY(4)) u_dut (
        .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
        .EXT_RST_N(EXT_RST_N), .FABRIC_RESET_N(FABRIC_RESET_N),
        .PERIPH_RESET_N(PERIPH_RESET_N), .CPU_RESET_N(CPU_RESET_N),
        .SEQ_DONE(SEQ_DONE), .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
    );

    proc_reset_sequencer u_def (
        .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
        .EXT_RST_N(EXT_RST_N), .FABRIC_RESET_N(def_fabric),
        .PERIPH_RESET_N(def_periph), .CPU_RESET_N(def_cpu),
        .SEQ_DONE(def_done), .LOCK_LOSS_CNT(def_loss)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    // Assert reset with all inputs good, release on a falling edge; edge_n
    // then counts rising edges with RESETN high.
    task automatic start_from_reset();
        RESETN = 1'b0;
        PLL_LOCK = 1'b1;
        INIT_DONE = 1'b1;
        EXT_RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        edge_n = 0;
    endtask

    // Records the edge number at which each output is first seen high.
    task automatic measure(input int limit, output int e_fab, output int e_per,
                           output int e_cpu, output int e_done);
        e_fab = -1; e_per = -1; e_cpu = -1; e_done = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (FABRIC_RESET_N === 1'b1 && e_fab < 0) e_fab = edge_n;
            if (PERIPH_RESET_N === 1'b1 && e_per < 0) e_per = edge_n;
            if (CPU_RESET_N === 1'b1 && e_cpu < 0) e_cpu = edge_n;
            if (SEQ_DONE === 1'b1 && e_done < 0) e_done = edge_n;
            if (e_cpu >= 0 && e_done >= 0) break;
        end
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        PLL_LOCK = 1'b1; INIT_DONE = 1'b1; EXT_RST_N = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (FABRIC_RESET_N !== 1'b0) begin n_errors++; $display("FAIL reset_fabric: got %b want 0", FABRIC_RESET_N); end
        n_checks++;
        if (PERIPH_RESET_N !== 1'b0) begin n_errors++; $display("FAIL reset_periph: got %b want 0", PERIPH_RESET_N); end
        n_checks++;
        if (CPU_RESET_N !== 1'b0) begin n_errors++; $display("FAIL reset_cpu: got %b want 0", CPU_RESET_N); end
        n_checks++;
        if (SEQ_DONE !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", SEQ_DONE); end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd0) begin n_errors++; $display("FAIL reset_loss: got %0d want 0", LOCK_LOSS_CNT); end
    endtask

    task automatic test_nominal();
        int ef, ep, ec, ed;
        start_from_reset();
        measure(40, ef, ep, ec, ed);
        n_checks++;
        if (ef != 11) begin n_errors++; $display("FAIL nominal_fabric_edge: got %0d want 11", ef); end
        n_checks++;
        if (ep != 15) begin n_errors++; $display("FAIL nominal_periph_edge: got %0d want 15", ep); end
        n_checks++;
        if (ec != 19) begin n_errors++; $display("FAIL nominal_cpu_edge: got %0d want 19", ec); end
        n_checks++;
        if (ed != 19) begin n_errors++; $display("FAIL nominal_done_edge: got %0d want 19", ed); end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd0) begin n_errors++; $display("FAIL nominal_loss: got %0d want 0", LOCK_LOSS_CNT); end
    endtask

    task automatic test_defaults();
        int ef, ep, ec;
        ef = -1; ep = -1; ec = -1;
        start_from_reset();
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (def_fabric === 1'b1 && ef < 0) ef = edge_n;
            if (def_periph === 1'b1 && ep < 0) ep = edge_n;
            if (def_cpu === 1'b1 && ec < 0) ec = edge_n;
            if (ec >= 0) break;
        end
        n_checks++;
        if (ef != 1027) begin n_errors++; $display("FAIL default_fabric_edge: got %0d want 1027", ef); end
        n_checks++;
        if (ep != 1043) begin n_errors++; $display("FAIL default_periph_edge: got %0d want 1043", ep); end
        n_checks++;
        if (ec != 1059) begin n_errors++; $display("FAIL default_cpu_edge: got %0d want 1059", ec); end
        n_checks++;
        if (def_done !== 1'b1) begin n_errors++; $display("FAIL default_done: got %b want 1", def_done); end
    endtask

    // PLL low for 3 cycles starting at cnt=5 in STABILIZE.
    task automatic test_stabilize_drop();
        int ef, ep, ec, ed, raise;
        start_from_reset();
        repeat (8) tick();
        PLL_LOCK = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (FABRIC_RESET_N !== 1'b0) begin n_errors++; $display("FAIL stab_drop_no_release: got %b want 0", FABRIC_RESET_N); end
        PLL_LOCK = 1'b1;
        raise = edge_n;
        measure(40, ef, ep, ec, ed);
        n_checks++;
        if (ef != raise + 11) begin n_errors++; $display("FAIL stab_drop_fabric_edge: got %0d want %0d", ef, raise + 11); end
        n_checks++;
        if (ec != raise + 19) begin n_errors++; $display("FAIL stab_drop_cpu_edge: got %0d want %0d", ec, raise + 19); end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd0) begin n_errors++; $display("FAIL stab_drop_loss: got %0d want 0", LOCK_LOSS_CNT); end
    endtask

    // One-cycle glitch just before terminal count must still restart the wait.
    task automatic test_stabilize_glitch();
        int ef, ep, ec, ed, raise;
        start_from_reset();
        repeat (8) tick();
        PLL_LOCK = 1'b0;
        tick();
        PLL_LOCK = 1'b1;
        raise = edge_n;
        measure(40, ef, ep, ec, ed);
        n_checks++;
        if (ef != raise + 11) begin n_errors++; $display("FAIL glitch_fabric_edge: got %0d want %0d", ef, raise + 11); end
        n_checks++;
        if (ep != raise + 15) begin n_errors++; $display("FAIL glitch_periph_edge: got %0d want %0d", ep, raise + 15); end
    endtask

    // Loss during REL_FABRIC must beat the pending peripheral release.
    task automatic test_abort_rel();
        start_from_reset();
        repeat (12) tick();
        PLL_LOCK = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (FABRIC_RESET_N !== 1'b1) begin n_errors++; $display("FAIL abort_fabric_still_high: got %b want 1", FABRIC_RESET_N); end
        tick();
        n_checks++;
        if (FABRIC_RESET_N !== 1'b0) begin n_errors++; $display("FAIL abort_fabric_low: got %b want 0", FABRIC_RESET_N); end
        n_checks++;
        if (PERIPH_RESET_N !== 1'b0) begin n_errors++; $display("FAIL abort_periph_low: got %b want 0", PERIPH_RESET_N); end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd0) begin n_errors++; $display("FAIL abort_loss: got %0d want 0", LOCK_LOSS_CNT); end
        PLL_LOCK = 1'b1;
    endtask

    task automatic test_run_loss();
        int ef, ep, ec, ed, raise;
        start_from_reset();
        measure(40, ef, ep, ec, ed);
        repeat (2) tick();
        PLL_LOCK = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE} !== 4'b1111) begin
            n_errors++; $display("FAIL run_loss_before: got %b want 1111", {FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE});
        end
        tick();
        n_checks++;
        if ({FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE} !== 4'b0000) begin
            n_errors++; $display("FAIL run_loss_after: got %b want 0000", {FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE});
        end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd1) begin n_errors++; $display("FAIL run_loss_count: got %0d want 1", LOCK_LOSS_CNT); end
        PLL_LOCK = 1'b1;
        raise = edge_n;
        measure(40, ef, ep, ec, ed);
        n_checks++;
        if (ef != raise + 11) begin n_errors++; $display("FAIL relock_fabric_edge: got %0d want %0d", ef, raise + 11); end
        n_checks++;
        if (ep != raise + 15) begin n_errors++; $display("FAIL relock_periph_edge: got %0d want %0d", ep, raise + 15); end
        n_checks++;
        if (ed != raise + 19) begin n_errors++; $display("FAIL relock_done_edge: got %0d want %0d", ed, raise + 19); end
    endtask

    // Continues from RUN left by test_run_loss (loss count 1).
    task automatic test_ext_rst();
        int ef, ep, ec, ed;
        EXT_RST_N = 1'b0;
        tick();
        EXT_RST_N = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE} !== 4'b0000) begin
            n_errors++; $display("FAIL ext_rst_outputs: got %b want 0000", {FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE});
        end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd1) begin n_errors++; $display("FAIL ext_rst_loss: got %0d want 1", LOCK_LOSS_CNT); end
        measure(40, ef, ep, ec, ed);
        INIT_DONE = 1'b0;
        repeat (3) tick();
        INIT_DONE = 1'b1;
        n_checks++;
        if (SEQ_DONE !== 1'b0) begin n_errors++; $display("FAIL init_drop_done: got %b want 0", SEQ_DONE); end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd1) begin n_errors++; $display("FAIL init_drop_loss: got %0d want 1", LOCK_LOSS_CNT); end
    endtask

    // RESETN dropped mid-cycle in REL_PERIPH clears outputs with no clock edge.
    task automatic test_async_reset();
        int ef, ep, ec, ed;
        start_from_reset();
        repeat (16) tick();
        #2;
        RESETN = 1'b0;
        #1;
        n_checks++;
        if ({FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE} !== 4'b0000) begin
            n_errors++; $display("FAIL async_reset_outputs: got %b want 0000", {FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE});
        end
        start_from_reset();
        measure(40, ef, ep, ec, ed);
        n_checks++;
        if (ef != 11) begin n_errors++; $display("FAIL async_restart_fabric: got %0d want 11", ef); end
        n_checks++;
        if (ec != 19) begin n_errors++; $display("FAIL async_restart_cpu: got %0d want 19", ec); end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        bit timed_out;
        exp_cnt = 0;
        timed_out = 1'b0;
        start_from_reset();
        for (int i = 0; i < 260; i++) begin
            for (int w = 0; w < 40 && SEQ_DONE !== 1'b1; w++) tick();
            if (SEQ_DONE !== 1'b1) begin
                timed_out = 1'b1;
                break;
            end
            PLL_LOCK = 1'b0;
            repeat (3) tick();
            PLL_LOCK = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
            n_checks++;
            if (LOCK_LOSS_CNT !== 8'(exp_cnt)) begin
                n_errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, LOCK_LOSS_CNT, exp_cnt);
            end
        end
        n_checks++;
        if (timed_out) begin n_errors++; $display("FAIL sat_run_timeout: got no SEQ_DONE want SEQ_DONE=1 within 40 edges"); end
        n_checks++;
        if (LOCK_LOSS_CNT !== 8'd255) begin n_errors++; $display("FAIL sat_final: got %0d want 255", LOCK_LOSS_CNT); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_defaults();
        test_stabilize_drop();
        test_stabilize_glitch();
        test_abort_rel();
        test_run_loss();
        test_ext_rst();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/proc_reset_sequencer.md
PROC_RESET_SEQUENCER -- requirements
Module: proc_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024: consecutive cycles all inputs must stay good before the first release; legal 2..65535.
REQ-002 SHALL have parameter STAGE_DELAY, default 16: cycles between successive reset releases; legal 1..65535.
REQ-003 SHALL have port CLK  input  1: the single clock, the 160 MHz RC oscillator global output; all logic on its rising edge.
REQ-004 SHALL have port RESETN  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port PLL_LOCK  input  1: asynchronous PLL lock indication.
REQ-006 SHALL have port INIT_DONE  input  1: asynchronous device-initialisation-complete flag.
REQ-007 SHALL have port EXT_RST_N  input  1: asynchronous external reset request, active-low.
REQ-008 SHALL have port FABRIC_RESET_N  output  1: stage-1 reset, active-low, registered.
REQ-009 SHALL have port PERIPH_RESET_N  output  1: stage-2 reset, active-low, registered.
REQ-010 SHALL have port CPU_RESET_N  output  1: stage-3 reset, active-low, registered.
REQ-011 SHALL have port SEQ_DONE  output  1: high while in RUN, registered.
REQ-012 SHALL have port LOCK_LOSS_CNT  output  8: saturating count of PLL-lock losses seen in RUN.

Function
REQ-013 SHALL pass PLL_LOCK, INIT_DONE, EXT_RST_N each through a 2-flop synchroniser reset to 0; good = AND of the three synchronised values.
REQ-014 SHALL implement states RESET_HOLD, WAIT_INPUTS, STABILIZE, REL_FABRIC, REL_PERIPH, RUN, with one 16-bit counter cnt.
REQ-015 RESET_HOLD: entered only by reset; next edge -> WAIT_INPUTS unconditionally.
REQ-016 WAIT_INPUTS: good=1 -> STABILIZE with cnt<=0; else stay.
REQ-017 STABILIZE: good=0 -> WAIT_INPUTS; good=1 and cnt==LOCK_CYCLES-1 -> REL_FABRIC, cnt<=0, FABRIC_RESET_N<=1; else cnt++.
REQ-018 REL_FABRIC: cnt==STAGE_DELAY-1 -> REL_PERIPH, cnt<=0, PERIPH_RESET_N<=1; else cnt++.
REQ-019 REL_PERIPH: cnt==STAGE_DELAY-1 -> RUN, CPU_RESET_N<=1, SEQ_DONE<=1; else cnt++.
REQ-020 In REL_FABRIC, REL_PERIPH or RUN, good=0 SHALL take priority over counting: next edge all four reset/done outputs <=0, state -> WAIT_INPUTS, cnt<=0.
REQ-021 Release order SHALL always be FABRIC, then PERIPH, then CPU; assertion (drop to 0) SHALL be simultaneous for all three.
REQ-022 LOCK_LOSS_CNT SHALL increment by 1 on the edge leaving RUN when synchronised PLL_LOCK=0, saturating at 255; losses outside RUN, or due only to INIT_DONE/EXT_RST_N, SHALL not count.
REQ-023 Glitches of good=0 lasting one synchronised cycle SHALL be honoured (no filtering); any sequence restarts from STABILIZE with full LOCK_CYCLES.
REQ-024 With inputs high before RESETN deasserts: good at edge 2, STABILIZE at edge 3, FABRIC_RESET_N high after edge 3+LOCK_CYCLES, PERIPH after edge 3+LOCK_CYCLES+STAGE_DELAY, CPU_RESET_N and SEQ_DONE after edge 3+LOCK_CYCLES+2*STAGE_DELAY (edges counted from first rising edge with RESETN high).

Reset
REQ-025 RESETN low SHALL immediately (asynchronously) force FABRIC_RESET_N, PERIPH_RESET_N, CPU_RESET_N, SEQ_DONE to 0, LOCK_LOSS_CNT to 0, cnt to 0, synchronisers to 0, state to RESET_HOLD.
REQ-026 Reset asserted mid-sequence or in RUN SHALL abort it with no partial release surviving; deassertion SHALL be synchronised by the instantiating reset bridge, not by this block.

Verification (LOCK_CYCLES=8, STAGE_DELAY=4 unless stated)
REQ-027 Inputs high, RESETN released -> FABRIC high after edge 11, PERIPH after edge 15, CPU_RESET_N and SEQ_DONE after edge 19, LOCK_LOSS_CNT=0.
REQ-028 PLL_LOCK low for 3 cycles during STABILIZE at cnt=5 -> no release; FABRIC_RESET_N rises exactly 8 cycles after good returns plus one entry edge.
REQ-029 In RUN, PLL_LOCK dropped -> all three resets and SEQ_DONE low 3 edges later (2 sync + 1 register), LOCK_LOSS_CNT=1; relock -> full sequence repeats.
REQ-030 In RUN, EXT_RST_N pulsed low -> outputs low, LOCK_LOSS_CNT unchanged; 260 PLL_LOCK losses in RUN -> LOCK_LOSS_CNT=255.
REQ-031 RESETN asserted while in REL_PERIPH -> PERIPH/FABRIC low with no clock edge; after release, sequence restarts from edge 1 timing of REQ-027.
REQ-032 Defaults LOCK_CYCLES=1024, STAGE_DELAY=16 -> CPU_RESET_N rises after edge 1059.
